// File: rtl/glyph_pkg.sv
// Shared glyph code tables, operator codes and assembler state encoding.
package glyph_pkg;

    localparam logic [5:0] C_D0   = 6'b101010;
    localparam logic [5:0] C_D1   = 6'b010101;
    localparam logic [5:0] C_D4   = 6'b100110;
    localparam logic [5:0] C_D6   = 6'b011011;
    localparam logic [5:0] C_D7   = 6'b010110;
    localparam logic [5:0] C_D8   = 6'b101011;
    localparam logic [5:0] C_D9   = 6'b100111;
    // Shared coarse shape for 2/3/5; the fine field separates them.
    localparam logic [5:0] C_FINE = 6'b010111;

    localparam logic [1:0] F_D2 = 2'b10;
    localparam logic [1:0] F_D5 = 2'b01;
    localparam logic [1:0] F_D3 = 2'b11;

    localparam logic [3:0] SYM_11 = 4'b1010;
    localparam logic [3:0] SYM_01 = 4'b0101;
    localparam logic [3:0] SYM_10 = 4'b0000;

    localparam logic [1:0] OP_01 = 2'b01;
    localparam logic [1:0] OP_10 = 2'b10;
    localparam logic [1:0] OP_11 = 2'b11;

    typedef enum logic [1:0] {S_A, S_B, S_OUT, S_ERR} state_t;

endpackage

// File: rtl/glyph_decode.sv
// Combinational classifier: turns one glyph feature record into a digit
// value or an operator code, flagging codes that match neither table.
module glyph_decode
    import glyph_pkg::*;
(
    input  logic       in_kind,
    input  logic [7:0] in_feat,
    input  logic [3:0] in_sym,
    output logic       is_digit,
    output logic [3:0] digit,
    output logic       is_sym,
    output logic [1:0] op,
    output logic       code_bad
);

    logic dig_ok;
    logic sym_ok;

    always_comb begin
        dig_ok = 1'b1;
        digit  = '0;
        case (in_feat[7:2])
            C_D0: digit = 4'd0;
            C_D1: digit = 4'd1;
            C_D4: digit = 4'd4;
            C_D6: digit = 4'd6;
            C_D7: digit = 4'd7;
            C_D8: digit = 4'd8;
            C_D9: digit = 4'd9;
            C_FINE: begin
                case (in_feat[1:0])
                    F_D2:    digit = 4'd2;
                    F_D5:    digit = 4'd5;
                    F_D3:    digit = 4'd3;
                    default: dig_ok = 1'b0;
                endcase
            end
            default: dig_ok = 1'b0;
        endcase
    end

    always_comb begin
        sym_ok = 1'b1;
        op     = '0;
        case (in_sym)
            SYM_11:  op = OP_11;
            SYM_01:  op = OP_01;
            SYM_10:  op = OP_10;
            default: sym_ok = 1'b0;
        endcase
    end

    assign is_digit = !in_kind && dig_ok;
    assign is_sym   = in_kind && sym_ok;
    assign code_bad = in_kind ? !sym_ok : !dig_ok;

endmodule

// File: rtl/glyph_expr_assembler.sv
// Streams glyph records into "A op B" expression records: FSM, decimal
// operand accumulators and a registered output held until downstream accepts.
module glyph_expr_assembler
    import glyph_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = 4,
    parameter int unsigned OP_W       = 14
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_kind,
    input  logic [7:0]      in_feat,
    input  logic [3:0]      in_sym,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] out_a,
    output logic [OP_W-1:0] out_b,
    output logic [1:0]      out_op,
    output logic            out_err
);

    localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

    state_t          state_q, state_d, proc_state;
    logic [OP_W-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
    logic [CW-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [1:0]      op_q, op_d;
    logic            err_q, err_d;
    logic            out_valid_q, out_valid_d;
    logic [OP_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
    logic [1:0]      out_op_q, out_op_d;
    logic            out_err_q, out_err_d;

    logic       is_digit, is_sym, code_bad, accept, fault;
    logic [3:0] digit;
    logic [1:0] dec_op;

    glyph_decode u_decode (
        .in_kind  (in_kind),
        .in_feat  (in_feat),
        .in_sym   (in_sym),
        .is_digit (is_digit),
        .digit    (digit),
        .is_sym   (is_sym),
        .op       (dec_op),
        .code_bad (code_bad)
    );

    // x*10 + d as shift-add; the digit-count limit keeps it within OP_W.
    function automatic logic [OP_W-1:0] mul10_add(input logic [OP_W-1:0] x,
                                                  input logic [3:0] d);
        return (x << 3) + (x << 1) + OP_W'(d);
    endfunction

    assign in_ready = (state_q != S_OUT);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        proc_state  = state_q;
        acc_a_d     = acc_a_q;
        acc_b_d     = acc_b_q;
        cnt_a_d     = cnt_a_q;
        cnt_b_d     = cnt_b_q;
        op_d        = op_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_op_d    = out_op_q;
        out_err_d   = out_err_q;
        fault       = 1'b0;

        if (accept) begin
            case (state_q)
                S_A: begin
                    if (code_bad) begin
                        fault = 1'b1;
                    end else if (is_digit) begin
                        if (cnt_a_q == CW'(MAX_DIGITS)) begin
                            fault = 1'b1;
                        end else begin
                            acc_a_d = mul10_add(acc_a_q, digit);
                            cnt_a_d = cnt_a_q + CW'(1);
                        end
                    end else if (is_sym) begin
                        if (cnt_a_q == '0) begin
                            fault = 1'b1;
                        end else begin
                            op_d       = dec_op;
                            proc_state = S_B;
                        end
                    end
                end
                S_B: begin
                    if (code_bad || is_sym) begin
                        fault = 1'b1;
                    end else if (is_digit) begin
                        if (cnt_b_q == CW'(MAX_DIGITS)) begin
                            fault = 1'b1;
                        end else begin
                            acc_b_d = mul10_add(acc_b_q, digit);
                            cnt_b_d = cnt_b_q + CW'(1);
                        end
                    end
                end
                default: ;
            endcase

            if (fault) begin
                err_d      = 1'b1;
                proc_state = S_ERR;
            end
            state_d = proc_state;

            // Record judged on the state/count after this glyph is applied.
            if (in_last) begin
                state_d     = S_OUT;
                out_valid_d = 1'b1;
                out_a_d     = acc_a_d;
                out_b_d     = acc_b_d;
                out_op_d    = op_d;
                out_err_d   = err_d || (proc_state != S_B) || (cnt_b_d == '0);
            end
        end else if (state_q == S_OUT && out_ready) begin
            state_d     = S_A;
            out_valid_d = 1'b0;
            acc_a_d     = '0;
            acc_b_d     = '0;
            cnt_a_d     = '0;
            cnt_b_d     = '0;
            op_d        = '0;
            err_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_A;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
            op_q        <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_op_q    <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_a_q     <= acc_a_d;
            acc_b_q     <= acc_b_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
            op_q        <= op_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_op_q    <= out_op_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_op    = out_op_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_glyph_expr_assembler.sv
// Scoreboard bench for glyph_expr_assembler: directed scenarios plus random
// expressions checked against a glyph-list reference model.
module tb_glyph_expr_assembler;

    localparam int MAXD = 4;
    localparam int OPW  = 14;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, in_kind, in_last;
    logic [7:0]     in_feat;
    logic [3:0]     in_sym;
    logic           out_valid, out_ready;
    logic [OPW-1:0] out_a, out_b;
    logic [1:0]     out_op;
    logic           out_err;

    always #5 clk = ~clk;

    glyph_expr_assembler #(.MAX_DIGITS(MAXD), .OP_W(OPW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_feat(in_feat), .in_sym(in_sym), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_err(out_err)
    );

    typedef struct {
        int unsigned a;
        int unsigned b;
        int unsigned op;
        bit          err;
    } rec_t;

    typedef struct {
        bit       kind;
        bit [7:0] feat;
        bit [3:0] sym;
    } glyph_t;

    rec_t        exp_q[$];
    int unsigned n_cmp = 0, n_bad = 0, n_tx = 0, n_rx = 0;
    int          rdy_mode = 1;   // 0 random, 1 hold low, 2 hold high

    int dmap[int];
    int fmap[int];
    int smap[int];
    bit [5:0] vcodes[8] = '{6'b101010, 6'b010101, 6'b100110, 6'b011011,
                            6'b010110, 6'b101011, 6'b100111, 6'b010111};

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int dval(input bit [7:0] f);
        int c = int'(f[7:2]);
        if (c == 6'b010111) return fmap.exists(int'(f[1:0])) ? fmap[int'(f[1:0])] : -1;
        return dmap.exists(c) ? dmap[c] : -1;
    endfunction

    function automatic rec_t model(input glyph_t g[$]);
        rec_t r;
        int a = 0, b = 0, na = 0, nb = 0, op = 0, v;
        bit in_b = 0, bad = 0;
        foreach (g[i]) begin
            if (bad) continue;
            if (!g[i].kind) begin
                v = dval(g[i].feat);
                if (v < 0) bad = 1;
                else if (!in_b) begin
                    if (na == MAXD) bad = 1; else begin a = a * 10 + v; na++; end
                end else begin
                    if (nb == MAXD) bad = 1; else begin b = b * 10 + v; nb++; end
                end
            end else begin
                if (!smap.exists(int'(g[i].sym)) || in_b || na == 0) bad = 1;
                else begin op = smap[int'(g[i].sym)]; in_b = 1; end
            end
        end
        r.a = a; r.b = b; r.op = op;
        r.err = bad || !in_b || nb == 0;
        return r;
    endfunction

    task automatic set_rdy(input int m);
        rdy_mode  = m;
        out_ready = (m == 2);
    endtask

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) out_ready = ($urandom % 4) != 0;
        else out_ready = (rdy_mode == 2);
    end

    // Compare every presented record against the scoreboard head; this also
    // proves the outputs hold steady while stalled.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_record", 1, 0);
            end else begin
                chk("rec_a", out_a, exp_q[0].a);
                chk("rec_b", out_b, exp_q[0].b);
                chk("rec_op", out_op, exp_q[0].op);
                chk("rec_err", out_err, exp_q[0].err);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_rx++;
                end
            end
        end
    end

    task automatic send_glyph(input glyph_t g, input bit last);
        bit ok = 0;
        in_kind  = g.kind;
        in_feat  = g.feat;
        in_sym   = g.sym;
        in_last  = last;
        in_valid = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic send_expr(input glyph_t g[$], input rec_t e, input bit gaps);
        foreach (g[i]) begin
            send_glyph(g[i], i == g.size() - 1);
            if (i == g.size() - 1) begin
                exp_q.push_back(e);
                n_tx++;
            end else if (gaps) begin
                repeat ($urandom % 3) @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        chk("latency_out_valid", out_valid, 1);
        chk("busy_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
    endtask

    function automatic glyph_t dg(input bit [7:0] f);
        glyph_t g;
        g.kind = 0; g.feat = f; g.sym = 4'($urandom);
        return g;
    endfunction

    function automatic glyph_t sg(input bit [3:0] s);
        glyph_t g;
        g.kind = 1; g.feat = 8'($urandom); g.sym = s;
        return g;
    endfunction

    function automatic rec_t mk(input int unsigned a, b, op, input bit err);
        rec_t r;
        r.a = a; r.b = b; r.op = op; r.err = err;
        return r;
    endfunction

    function automatic glyph_t rand_digit();
        bit [1:0] fine;
        int idx;
        if ($urandom % 10 == 0) return dg(8'($urandom));
        idx  = $urandom_range(0, 7);
        fine = 2'($urandom);
        if (idx == 7 && fine == 2'b00) fine = 2'b11;
        return dg({vcodes[idx], fine});
    endfunction

    function automatic glyph_t rand_sym();
        bit [3:0] s[3] = '{4'b1010, 4'b0101, 4'b0000};
        if ($urandom % 8 == 0) return sg(4'($urandom));
        return sg(s[$urandom_range(0, 2)]);
    endfunction

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_err", out_err, 0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        glyph_t g[$];
        dmap[6'b101010] = 0; dmap[6'b010101] = 1; dmap[6'b100110] = 4;
        dmap[6'b011011] = 6; dmap[6'b010110] = 7; dmap[6'b101011] = 8;
        dmap[6'b100111] = 9;
        fmap[2'b10] = 2; fmap[2'b01] = 5; fmap[2'b11] = 3;
        smap[4'b1010] = 3; smap[4'b0101] = 1; smap[4'b0000] = 2;

        in_valid = 0; in_kind = 0; in_feat = '0; in_sym = '0; in_last = 0;
        out_ready = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_a", out_a, 0);
        chk("reset_out_b", out_b, 0);
        chk("reset_out_op", out_op, 0);
        chk("reset_out_err", out_err, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // "12 op 7" under backpressure
        set_rdy(1);
        g = '{dg(8'h54), dg(8'h5E), sg(4'b1010), dg(8'h58)};
        send_expr(g, mk(12, 7, 3, 0), 0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        set_rdy(2);
        @(posedge clk);
        @(negedge clk);
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Operand A overflow
        g = '{dg(8'h54), dg(8'h54), dg(8'h54), dg(8'h54), dg(8'h54), sg(4'b0101), dg(8'h54)};
        send_expr(g, mk(1111, 0, 0, 1), 0);

        // Invalid code mid-A, junk afterwards, single record
        g = '{dg(8'h54), dg(8'h5C), sg(4'b1111), dg(8'h00), sg(4'b0101), dg(8'h5E), dg(8'h58)};
        send_expr(g, mk(1, 0, 0, 1), 0);

        // Missing operand B
        g = '{dg(8'h54), sg(4'b0000)};
        send_expr(g, mk(1, 0, 2, 1), 0);

        // Reset mid-S_B, then "3 op 3"
        send_glyph(dg(8'h54), 0);
        send_glyph(sg(4'b0101), 0);
        send_glyph(dg(8'h5E), 0);
        pulse_reset();
        @(posedge clk);
        #1;
        g = '{dg(8'h5F), sg(4'b0101), dg(8'h5F)};
        send_expr(g, mk(3, 3, 1, 0), 0);

        // Reset while a record is stalled: record is discarded
        set_rdy(1);
        g = '{dg(8'h5F), sg(4'b1010), dg(8'h5E)};
        send_expr(g, mk(3, 2, 3, 0), 0);
        pulse_reset();
        exp_q.delete();
        n_tx--;
        @(posedge clk);
        #1;

        // Randomized expressions against the reference model
        set_rdy(0);
        for (int n = 0; n < 150; n++) begin
            int na = ($urandom % 10 == 0) ? 0 : $urandom_range(1, 5);
            int nb = $urandom_range(0, 5);
            g = {};
            for (int i = 0; i < na; i++) g.push_back(rand_digit());
            if ($urandom % 10 != 0) g.push_back(rand_sym());
            for (int i = 0; i < nb; i++) g.push_back(rand_digit());
            if ($urandom % 8 == 0) begin
                int pos = $urandom_range(0, g.size());
                g.insert(pos, ($urandom % 2) ? rand_sym() : rand_digit());
            end
            if (g.size() == 0) g.push_back(rand_digit());
            send_expr(g, model(g), 1);
        end

        set_rdy(2);
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("record_count", n_rx, n_tx);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
